// File: rtl/sys_types.sv
// Shared scalar types used across the datapath blocks.
package sys_types;

  typedef logic signed [7:0] int8_t;

endpackage

// File: rtl/unflatten_layer_pkg.sv
// Defaults and width helpers shared by the unflatten block, its stream interface and counter.
package unflatten_layer_pkg;

  localparam int unsigned DefaultHeight   = 2;
  localparam int unsigned DefaultWidth    = 2;
  localparam int unsigned DefaultChannels = 64;

  // Index width for a range of n values; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/unflatten_layer_if.sv
// Position stream leaving the unflatten stage: one spatial position per transfer.
interface unflatten_layer_if
  import sys_types::*;
  import unflatten_layer_pkg::*;
#(
  parameter int unsigned CHANNELS = DefaultChannels,
  parameter int unsigned ROW_W    = 1,
  parameter int unsigned COL_W    = 1
);

  logic             frame_start;
  int8_t            output_data [0:CHANNELS-1];
  logic [ROW_W-1:0] output_row;
  logic [COL_W-1:0] output_col;
  logic             output_valid;
  logic             out_ready;

  modport master (
    output frame_start,
    output output_data,
    output output_row,
    output output_col,
    output output_valid,
    input  out_ready
  );

  modport slave (
    input  frame_start,
    input  output_data,
    input  output_row,
    input  output_col,
    input  output_valid,
    output out_ready
  );

endinterface

// File: rtl/unflatten_layer_raster_counter.sv
// Row-major row/col counter with clear, enable and a last-position flag.
module unflatten_layer_raster_counter #(
  parameter int unsigned Height = 2,
  parameter int unsigned Width  = 2,
  parameter int unsigned RowW   = 1,
  parameter int unsigned ColW   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            enable_i,
  output logic [RowW-1:0] row_o,
  output logic [ColW-1:0] col_o,
  output logic            last_o
);

  localparam logic [RowW-1:0] RowMax = RowW'(Height - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(Width - 1);

  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;

  // Advance one position per enable; wrap the frame after the last position.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (enable_i) begin
      if (col_q == ColMax) begin
        col_q <= '0;
        row_q <= (row_q == RowMax) ? '0 : row_q + RowW'(1);
      end else begin
        col_q <= col_q + ColW'(1);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == RowMax) && (col_q == ColMax);

endmodule

// File: rtl/unflatten_layer.sv
// Captures a flat int8 vector and replays it as a row-major stream of spatial positions.
module unflatten_layer
  import sys_types::*;
  import unflatten_layer_pkg::*;
#(
  parameter int unsigned OUTPUT_HEIGHT   = DefaultHeight,
  parameter int unsigned OUTPUT_WIDTH    = DefaultWidth,
  parameter int unsigned OUTPUT_CHANNELS = DefaultChannels,
  parameter int unsigned INPUT_SIZE      = OUTPUT_HEIGHT * OUTPUT_WIDTH * OUTPUT_CHANNELS
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  start_unflatten,
  input  int8_t input_data [0:INPUT_SIZE-1],
  output logic  busy,
  output logic  unflatten_complete,
  unflatten_layer_if.master out_stream
);

  localparam int unsigned RowW = idx_width(OUTPUT_HEIGHT);
  localparam int unsigned ColW = idx_width(OUTPUT_WIDTH);
  localparam int unsigned IdxW = idx_width(INPUT_SIZE);

  typedef enum logic [1:0] {StIdle, StPriming, StStreaming, StComplete} state_e;

  state_e          state_q;
  logic            busy_q, frame_start_q, valid_q, complete_q;
  int8_t           buffer_q [0:INPUT_SIZE-1];
  logic            capture, transfer, last_pos;
  logic [RowW-1:0] row;
  logic [ColW-1:0] col;
  logic [IdxW-1:0] base;

  assign capture  = start_unflatten && (state_q == StIdle || state_q == StComplete);
  assign transfer = valid_q && out_stream.out_ready;

  // Frame sequencing; status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      valid_q       <= 1'b0;
      complete_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StComplete: begin
          if (start_unflatten) begin
            state_q       <= StPriming;
            busy_q        <= 1'b1;
            frame_start_q <= 1'b1;
            complete_q    <= 1'b0;
          end
        end
        StPriming: begin
          state_q       <= StStreaming;
          frame_start_q <= 1'b0;
          valid_q       <= 1'b1;
        end
        StStreaming: begin
          if (transfer && last_pos) begin
            state_q    <= StComplete;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            complete_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Buffer changes only on an accepted start, so input_data is free after capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(INPUT_SIZE); i++) buffer_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < int'(INPUT_SIZE); i++) buffer_q[i] <= input_data[i];
    end
  end

  unflatten_layer_raster_counter #(
    .Height (OUTPUT_HEIGHT),
    .Width  (OUTPUT_WIDTH),
    .RowW   (RowW),
    .ColW   (ColW)
  ) u_raster (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q == StPriming),
    .enable_i (transfer),
    .row_o    (row),
    .col_o    (col),
    .last_o   (last_pos)
  );

  // Position payload, zeroed outside streaming.
  always_comb begin
    base = (IdxW'(row) * IdxW'(OUTPUT_WIDTH) + IdxW'(col)) * IdxW'(OUTPUT_CHANNELS);
    out_stream.output_row = '0;
    out_stream.output_col = '0;
    for (int c = 0; c < int'(OUTPUT_CHANNELS); c++) out_stream.output_data[c] = '0;
    if (valid_q) begin
      out_stream.output_row = row;
      out_stream.output_col = col;
      for (int c = 0; c < int'(OUTPUT_CHANNELS); c++) begin
        out_stream.output_data[c] = buffer_q[base + IdxW'(c)];
      end
    end
  end

  assign out_stream.frame_start  = frame_start_q;
  assign out_stream.output_valid = valid_q;
  assign busy                    = busy_q;
  assign unflatten_complete      = complete_q;

endmodule

// File: doc/unflatten_layer.md
Name: unflatten_layer

Overview:
Transmit-side counterpart of the flatten stage. It captures a flat int8 vector in a single cycle and replays it as a row-major stream of spatial positions: one position per transfer, carrying all channels plus row/col. A one-cycle frame_start pulse precedes the stream so it can drive a flatten stage's start input directly. Typical uses are reshaping dense-layer output back to HxWxC and loopback test of the flatten path.

Parameters:
OUTPUT_HEIGHT, 2, spatial rows emitted; must be >= 2.
OUTPUT_WIDTH, 2, spatial columns emitted; must be >= 2.
OUTPUT_CHANNELS, 64, int8 elements per spatial position.
INPUT_SIZE, OUTPUT_HEIGHT*OUTPUT_WIDTH*OUTPUT_CHANNELS (256), length of the flat input vector.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
start_unflatten  input  1  capture input_data and begin a frame; honoured only in IDLE or COMPLETE.
input_data  input  int8_t[0:INPUT_SIZE-1]  flat vector, element index = (row*W+col)*C+ch.
out_ready  input  1  downstream accepts the current position this cycle.
busy  output  1  high in PRIMING or STREAMING.
frame_start  output  1  one-cycle pulse, asserted in PRIMING.
output_data  output  int8_t[0:OUTPUT_CHANNELS-1]  channels of the current position.
output_row  output  $clog2(OUTPUT_HEIGHT)  current row.
output_col  output  $clog2(OUTPUT_WIDTH)  current column.
output_valid  output  1  current position is valid (STREAMING).
unflatten_complete  output  1  level; high in COMPLETE.

Behaviour:
- Reset: state IDLE, capture buffer cleared to 0, row/col counters 0. All outputs are 0 from the cycle after reset is sampled. Reset asserted mid-frame aborts the frame the same way; no partial completion is reported.
- States:
  - IDLE: start_unflatten=1 latches all INPUT_SIZE elements into the buffer and moves to PRIMING.
  - PRIMING: one cycle, frame_start=1, counters forced to (0,0), then STREAMING.
  - STREAMING: output_valid=1. output_data[c] = buffer[(row*W+col)*C + c]. A transfer occurs when output_valid && out_ready. On transfer, col increments; at col=W-1, col wraps to 0 and row increments. A transfer at (H-1, W-1) moves to COMPLETE.
  - COMPLETE: unflatten_complete=1. start_unflatten=1 re-captures input_data and goes to PRIMING; unflatten_complete drops the next cycle.
- start_unflatten is ignored in PRIMING and STREAMING. The buffer is written only on an accepted start, so input_data may change freely after capture.
- out_ready=0 in STREAMING holds output_data, output_row, output_col and output_valid stable; unlimited stall.
- Outside STREAMING: output_valid=0, output_data all 0, output_row=output_col=0.
- Outputs are derived only from registered state, counters and buffer; there is no combinational path from any input to any output.
- Timing with start sampled at edge N and out_ready held at 1:
  - frame_start in cycle N+1.
  - Positions in cycles N+2 .. N+1+H*W.
  - unflatten_complete from cycle N+2+H*W.
  - Each stalled cycle adds 1 to this timing.
- Frame timing matches the flatten stage's input protocol: that stage is COLLECTING from the cycle after it samples start, i.e. the first valid position.
- Index arithmetic: base = (row*W+col)*C, computed at $clog2(INPUT_SIZE) bits; no overflow given the parameter constraints.

Decomposition:
- int8_t comes from the shared sys_types package.
- The state enum (IDLE, PRIMING, STREAMING, COMPLETE) is local to the module.
- One natural sub-module: raster_counter, a row/col counter with enable, clear, wrap and last-position flag, parameterised on height/width and reusable by other spatial streamers.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> all outputs 0; busy=0; unflatten_complete=0.
- Default params, input_data[i] = i[7:0] as signed, start at edge N, out_ready=1:
  - frame_start only in N+1.
  - (row,col) = (0,0),(0,1),(1,0),(1,1) in N+2..N+5.
  - output_data[0] = 0, 64, -128, -64; output_data[63] = 63, 127, -65, -1.
  - unflatten_complete from N+6.
- Backpressure: drop out_ready for 3 cycles while at (0,1) -> outputs frozen at (0,1) with data[0]=64; completion moves to N+9.
- Ignored start/input change: pulse start_unflatten and overwrite input_data with 0x55 during STREAMING -> no restart, stream data unchanged.
- Back-to-back frames: in COMPLETE, start with input_data all -1:
  - complete drops next cycle, then frame_start.
  - Four positions with all channels -1.
- Reset mid-stream at (1,0) -> next cycle IDLE with all outputs 0; a following start streams from (0,0).
- Loopback: connect frame_start/output_valid/output_data/output_row/output_col to a flatten stage's start/valid/data/row/col -> its flattened_data equals the original input_data element-for-element once complete.
